// File: rtl/mux_pkg.sv
// Shared types for the 4-to-1 round-robin stream merge: channel count, select width, state view.
package mux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Debug view of the output register: FULL exactly when out_valid is set.
  typedef enum logic {ST_EMPTY, ST_FULL} st_t;
endpackage

// File: rtl/mux4to1_rr_stream_arb.sv
// Combinational rotating-priority arbiter: picks the first requester at or after ptr (mod 4).
// Zero latency; no state, so backpressure is handled entirely by the caller gating the grant.
module rr_arbiter4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic [NUM_CH-1:0] grant,
  output sel_t              gidx,
  output logic              any
);

  sel_t idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + sel_t'(k);
      if (!any && req[idx]) begin
        any         = 1'b1;
        gidx        = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4to1_rr_stream.sv
// Merges four valid/ready channels onto one stream tagged with its source index, round-robin.
// One registered stage: 1-cycle latency, full throughput; a stalled output blocks all in_ready.
module mux4to1_rr_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    e,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output sel_t                    out_sel,
  output logic [CNT_W-1:0]        xfer_count
);

  st_t               state;
  sel_t              ptr;
  logic [NUM_CH-1:0] grant;
  sel_t              gidx;
  logic              any;
  logic              load_ok;
  logic              load;
  logic              drain;
  logic [WIDTH-1:0]  ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter4 u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  assign out_valid = (state == ST_FULL);
  assign load_ok   = e & (~out_valid | out_ready);
  assign load      = load_ok & any;
  assign drain     = out_valid & out_ready;
  // Reset must also hide the grant, since the edge it lands on discards everything.
  assign in_ready  = (load_ok & ~reset) ? grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      out_data   <= '0;
      out_sel    <= '0;
      ptr        <= '0;
      xfer_count <= '0;
    end else begin
      if (drain) begin
        xfer_count <= xfer_count + CNT_W'(1);
      end
      if (load) begin
        state    <= ST_FULL;
        out_data <= ch_data[gidx];
        out_sel  <= gidx;
        ptr      <= gidx + sel_t'(1);
      end else if (drain) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule
